// File: rtl/aes_byte_sequencer.sv
// aes_byte_sequencer
//   Host-side initiator for an AES-128 core with a start/done handshake.
//   It collects a 16-byte key and a 16-byte text block from a valid/ready
//   byte stream. It then pulses start to the core and holds text, key and
//   mode stable while it waits for done. It captures the core result and
//   streams it back out as 16 bytes, MSB byte first.
//
//   Build option: define AES_SEQ_CBC_EN to add CBC chaining and the
//   i_fChainClr port. Without it the block runs in plain ECB.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in WAIT for i_fCoreDone before abort (>=32)
//
// Ports
//   i_Clk, i_Rst        clock; synchronous active-high reset
//   i_Byte/i_fByteValid input byte stream; o_fByteReady high in LOAD
//   i_fKeySel           1: byte goes to key buffer, 0: text buffer
//   i_fDec              mode for the next block, sampled in START
//   o_Byte/o_fByteValid output byte stream (SEND); i_fByteReady from sink
//   o_fCoreStart        one-cycle start pulse to the core
//   o_fCoreDec          latched mode to the core
//   o_CoreText          block to the core, stable START..WAIT
//   o_CoreKey           key to the core, stable outside LOAD
//   i_CoreData          core result, valid with i_fCoreDone
//   i_fCoreDone         one-cycle done flag from the core
//   i_fChainClr         (AES_SEQ_CBC_EN only) clears chain register in LOAD
//   o_fBusy             sequencer not in LOAD
//   o_fTimeout          sticky core-timeout flag, cleared only by reset
module aes_byte_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [7:0]   i_Byte,
  input  logic         i_fByteValid,
  input  logic         i_fKeySel,
  input  logic         i_fDec,
  output logic         o_fByteReady,
  output logic [7:0]   o_Byte,
  output logic         o_fByteValid,
  input  logic         i_fByteReady,
  output logic         o_fCoreStart,
  output logic         o_fCoreDec,
  output logic [127:0] o_CoreText,
  output logic [127:0] o_CoreKey,
  input  logic [127:0] i_CoreData,
  input  logic         i_fCoreDone,
`ifdef AES_SEQ_CBC_EN
  input  logic         i_fChainClr,
`endif
  output logic         o_fBusy,
  output logic         o_fTimeout
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_SEND
  } state_t;

  state_t state, state_nxt;

  logic [127:0] key_buf;
  logic [127:0] text_buf;
  logic [127:0] out_buf;
  logic [3:0]   key_cnt;
  logic [3:0]   text_cnt;
  logic [3:0]   send_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic         dec_q;
  logic         timeout_q;

  logic         key_acc;
  logic         text_acc;
  logic         send_acc;
  logic         wait_last;
  logic [127:0] core_text;
  logic [127:0] result;

`ifdef AES_SEQ_CBC_EN
  logic [127:0] chain;
  logic         mode_dec;

  // In START the mode register is not yet loaded, so the live i_fDec selects
  // the chained text; from WAIT onward the latched mode keeps it stable.
  assign mode_dec  = (state == ST_START) ? i_fDec : dec_q;
  assign core_text = mode_dec ? text_buf : (text_buf ^ chain);
  assign result    = dec_q ? (i_CoreData ^ chain) : i_CoreData;
`else
  assign core_text = text_buf;
  assign result    = i_CoreData;
`endif

  assign key_acc   = (state == ST_LOAD) && i_fByteValid && i_fKeySel;
  assign text_acc  = (state == ST_LOAD) && i_fByteValid && !i_fKeySel;
  assign send_acc  = (state == ST_SEND) && i_fByteReady;
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (text_acc && (text_cnt == 4'd15)) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      // Done takes priority over the timeout limit on the same cycle.
      ST_WAIT: begin
        if (i_fCoreDone)    state_nxt = ST_SEND;
        else if (wait_last) state_nxt = ST_LOAD;
      end
      ST_SEND:  if (send_acc && (send_cnt == 4'd15)) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      key_buf   <= '0;
      text_buf  <= '0;
      out_buf   <= '0;
      key_cnt   <= '0;
      text_cnt  <= '0;
      send_cnt  <= '0;
      wait_cnt  <= '0;
      dec_q     <= 1'b0;
      timeout_q <= 1'b0;
`ifdef AES_SEQ_CBC_EN
      chain     <= '0;
`endif
    end else begin
      // ~cnt*8 places byte 0 at [127:120] and byte 15 at [7:0].
      if (key_acc) begin
        key_buf[{~key_cnt, 3'b000} +: 8] <= i_Byte;
        key_cnt <= key_cnt + 4'd1;
      end
      if (text_acc) begin
        text_buf[{~text_cnt, 3'b000} +: 8] <= i_Byte;
        text_cnt <= text_cnt + 4'd1;
      end
      if (state == ST_START) begin
        dec_q    <= i_fDec;
        wait_cnt <= '0;
      end
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        if (i_fCoreDone) begin
          out_buf <= result;
`ifdef AES_SEQ_CBC_EN
          chain   <= dec_q ? text_buf : i_CoreData;
`endif
        end else if (wait_last) begin
          timeout_q <= 1'b1;
        end
      end
      if (send_acc) begin
        out_buf  <= {out_buf[119:0], 8'h00};
        send_cnt <= send_cnt + 4'd1;
      end
`ifdef AES_SEQ_CBC_EN
      if ((state == ST_LOAD) && i_fChainClr) chain <= '0;
`endif
    end
  end

  assign o_fByteReady = (state == ST_LOAD);
  assign o_fByteValid = (state == ST_SEND);
  assign o_fCoreStart = (state == ST_START);
  assign o_fBusy      = (state != ST_LOAD);
  assign o_Byte       = out_buf[127:120];
  assign o_fCoreDec   = dec_q;
  assign o_CoreText   = core_text;
  assign o_CoreKey    = key_buf;
  assign o_fTimeout   = timeout_q;

endmodule

// File: tb/tb_aes_byte_sequencer.sv
`timescale 1ns/1ps
module tb_aes_byte_sequencer;

  localparam int TO = 48;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         i_Clk, i_Rst;
  logic [7:0]   i_Byte;
  logic         i_fByteValid, i_fKeySel, i_fDec;
  logic         o_fByteReady;
  logic [7:0]   o_Byte;
  logic         o_fByteValid, i_fByteReady;
  logic         o_fCoreStart, o_fCoreDec;
  logic [127:0] o_CoreText, o_CoreKey, i_CoreData;
  logic         i_fCoreDone, o_fBusy, o_fTimeout;
`ifdef AES_SEQ_CBC_EN
  logic         i_fChainClr;
`endif

  aes_byte_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_Byte(i_Byte), .i_fByteValid(i_fByteValid), .i_fKeySel(i_fKeySel),
    .i_fDec(i_fDec), .o_fByteReady(o_fByteReady),
    .o_Byte(o_Byte), .o_fByteValid(o_fByteValid), .i_fByteReady(i_fByteReady),
    .o_fCoreStart(o_fCoreStart), .o_fCoreDec(o_fCoreDec),
    .o_CoreText(o_CoreText), .o_CoreKey(o_CoreKey),
    .i_CoreData(i_CoreData), .i_fCoreDone(i_fCoreDone),
`ifdef AES_SEQ_CBC_EN
    .i_fChainClr(i_fChainClr),
`endif
    .o_fBusy(o_fBusy), .o_fTimeout(o_fTimeout)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int vectors = 0;
  int miscompares = 0;
  int start_pulses = 0;

  always @(posedge i_Clk) if (o_fCoreStart === 1'b1) start_pulses++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state: what the sequencer should hold, built from bytes.
  logic [127:0] m_key, m_text, m_chain;
  int m_kcnt, m_tcnt;

  task automatic reset_model();
    m_key = '0; m_text = '0; m_chain = '0; m_kcnt = 0; m_tcnt = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Toy invertible core: FIPS-197 vector pair, else rotate(text ^ key).
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t,
                                           input logic d);
    logic [127:0] x;
    if (k == FIPS_K && !d && t == FIPS_P) return FIPS_C;
    if (k == FIPS_K && d && t == FIPS_C) return FIPS_P;
    if (!d) begin
      x = t ^ k;
      return {x[119:0], x[127:120]};
    end
    x = {t[7:0], t[127:8]};
    return x ^ k;
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic drive_one(input logic [7:0] b, input logic ks);
    i_Byte = b; i_fKeySel = ks; i_fByteValid = 1'b1;
    tick();
    i_fByteValid = 1'b0; i_fKeySel = 1'($urandom()); i_Byte = 8'($urandom());
    if (ks) begin
      m_key[8*(15-m_kcnt) +: 8] = b;
      m_kcnt = (m_kcnt + 1) % 16;
    end else begin
      m_text[8*(15-m_tcnt) +: 8] = b;
      m_tcnt = (m_tcnt + 1) % 16;
    end
  endtask

  task automatic chain_clear();
`ifdef AES_SEQ_CBC_EN
    i_fChainClr = 1'b1;
    tick();
    i_fChainClr = 1'b0;
    m_chain = '0;
`endif
  endtask

  // Interleaves nkey key bytes with the text; the 16th text byte goes last.
  task automatic load_block(input logic [127:0] txt, input int nkey, input logic [127:0] key);
    int ki, ti;
    ki = 0; ti = 0;
    while (ti < 15 || ki < nkey) begin
      if (ki < nkey && (ti >= 15 || $urandom_range(1, 0) == 1)) begin
        drive_one(key[8*(15-ki) +: 8], 1'b1); ki++;
      end else begin
        drive_one(txt[8*(15-ti) +: 8], 1'b0); ti++;
      end
      repeat ($urandom_range(2, 0)) tick();
    end
    drive_one(txt[7:0], 1'b0);
  endtask

  // Entered in the START cycle; done is raised on WAIT cycle n; returns in SEND.
  task automatic wait_phase(input int n, input logic [127:0] data, input logic [127:0] etext,
                            input logic [127:0] ekey, input logic edec, output int bad);
    bad = 0;
    for (int j = 0; j <= n; j++) begin
      tick();
      if (j == 0) i_fDec = 1'($urandom());
      if (o_fCoreStart !== 1'b0 || o_CoreText !== etext || o_CoreKey !== ekey ||
          o_fCoreDec !== edec || o_fByteValid !== 1'b0 || o_fBusy !== 1'b1) bad++;
      if (j == n) begin i_fCoreDone = 1'b1; i_CoreData = data; end
      else i_CoreData = rnd128();
    end
    tick();
    i_fCoreDone = 1'b0; i_CoreData = rnd128();
  endtask

  // bp: 0 always ready, 1 toggle every other cycle, 2 random.
  task automatic collect(input int bp, output logic [127:0] got, output int bad);
    int n, guard;
    logic r, held;
    logic [7:0] prev;
    got = '0; bad = 0; n = 0; guard = 0; held = 1'b0; prev = '0;
    while (n < 16 && guard < 400) begin
      guard++;
      if (o_fByteValid !== 1'b1 || o_fByteReady !== 1'b0 || o_fBusy !== 1'b1) bad++;
      if (held && o_Byte !== prev) bad++;
      r = (bp == 0) ? 1'b1 : (bp == 1) ? 1'(guard % 2 == 0) : 1'($urandom_range(1, 0));
      i_fByteReady = r;
      if (r) begin got = {got[119:0], o_Byte}; n++; held = 1'b0; end
      else begin held = 1'b1; prev = o_Byte; end
      tick();
    end
    i_fByteReady = 1'b0;
    if (n < 16) bad += 100;
  endtask

  task automatic run_block(input logic [127:0] txt, input int nkey, input logic [127:0] key,
                           input logic dec, input int delay, input int bp,
                           output logic [127:0] got, output logic [127:0] exp,
                           output int bad, output logic start_ok);
    logic [127:0] ct, data;
    int b1, b2;
    i_fDec = dec;
    load_block(txt, nkey, key);
    ct = m_text;
`ifdef AES_SEQ_CBC_EN
    if (!dec) ct = m_text ^ m_chain;
`endif
    start_ok = (o_fCoreStart === 1'b1 && o_fBusy === 1'b1 && o_fByteReady === 1'b0 &&
                o_CoreText === ct && o_CoreKey === m_key);
    data = core_fn(m_key, ct, dec);
    exp = data;
`ifdef AES_SEQ_CBC_EN
    if (dec) begin exp = data ^ m_chain; m_chain = m_text; end
    else m_chain = data;
`endif
    wait_phase(delay, data, ct, m_key, dec, b1);
    collect(bp, got, b2);
    bad = b1 + b2;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (3) tick();
    reset_model();
    vectors++;
    if (o_fByteReady !== 1'b1 || o_fBusy !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: ready=%b busy=%b want 1/0", o_fByteReady, o_fBusy);
    end
    vectors++;
    if (o_fByteValid !== 1'b0 || o_Byte !== 8'h00 || o_fCoreStart !== 1'b0 ||
        o_fCoreDec !== 1'b0 || o_fTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: valid=%b byte=%h start=%b dec=%b to=%b want all 0",
               o_fByteValid, o_Byte, o_fCoreStart, o_fCoreDec, o_fTimeout);
    end
    vectors++;
    if (o_CoreText !== '0 || o_CoreKey !== '0) begin
      miscompares++; $display("FAIL reset_bufs: text=%h key=%h want 0", o_CoreText, o_CoreKey);
    end
    i_Rst = 1'b0;
  endtask

  task automatic test_fips();
    logic [127:0] got, exp;
    int bad, s0;
    logic sok;
    chain_clear();
    s0 = start_pulses;
    run_block(FIPS_P, 16, FIPS_K, 1'b0, 5, 0, got, exp, bad, sok);
    vectors++;
    if (got !== FIPS_C) begin miscompares++; $display("FAIL fips_enc: got %h want %h", got, FIPS_C); end
    vectors++;
    if (sok !== 1'b1 || bad !== 0) begin
      miscompares++; $display("FAIL fips_enc_proto: start_ok=%b bad=%0d want 1/0", sok, bad);
    end
    vectors++;
    if (start_pulses - s0 !== 1) begin
      miscompares++; $display("FAIL fips_start_count: got %0d want 1", start_pulses - s0);
    end
    vectors++;
    if (o_fByteReady !== 1'b1 || o_fBusy !== 1'b0) begin
      miscompares++; $display("FAIL fips_back_load: ready=%b busy=%b want 1/0", o_fByteReady, o_fBusy);
    end
  endtask

  task automatic test_fips_dec();
    logic [127:0] got, exp;
    int bad;
    logic sok;
    chain_clear();
    run_block(FIPS_C, 0, '0, 1'b1, 3, 0, got, exp, bad, sok);
    vectors++;
    if (got !== FIPS_P) begin miscompares++; $display("FAIL fips_dec: got %h want %h", got, FIPS_P); end
    vectors++;
    if (sok !== 1'b1 || bad !== 0) begin
      miscompares++; $display("FAIL fips_dec_proto: start_ok=%b bad=%0d want 1/0", sok, bad);
    end
  endtask

  task automatic test_done_at_limit();
    logic [127:0] got, exp;
    int bad;
    logic sok;
    run_block(rnd128(), 0, '0, 1'($urandom()), TO - 1, 0, got, exp, bad, sok);
    vectors++;
    if (got !== exp || bad !== 0) begin
      miscompares++; $display("FAIL done_at_limit: got %h want %h bad=%0d", got, exp, bad);
    end
    vectors++;
    if (o_fTimeout !== 1'b0) begin
      miscompares++; $display("FAIL done_at_limit_to: timeout=%b want 0", o_fTimeout);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] got, exp;
    int bad;
    logic sok;
    run_block(rnd128(), 16, rnd128(), 1'b0, 0, 1, got, exp, bad, sok);
    vectors++;
    if (got !== exp || bad !== 0 || sok !== 1'b1) begin
      miscompares++; $display("FAIL backpressure: got %h want %h bad=%0d", got, exp, bad);
    end
  endtask

  task automatic test_key_wrap();
    logic [127:0] got, exp;
    int bad;
    logic sok;
    for (int i = 0; i < 17; i++) drive_one(8'($urandom()), 1'b1);
    run_block(rnd128(), 0, '0, 1'b0, 2, 0, got, exp, bad, sok);
    vectors++;
    if (got !== exp || bad !== 0 || sok !== 1'b1) begin
      miscompares++; $display("FAIL key_wrap: got %h want %h bad=%0d start_ok=%b", got, exp, bad, sok);
    end
  endtask

  task automatic test_random();
    logic [127:0] got, exp;
    int bad;
    logic sok;
    for (int it = 0; it < 8; it++) begin
      run_block(rnd128(), ($urandom_range(1, 0) == 1) ? 16 : 0, rnd128(), 1'($urandom()),
                $urandom_range(30, 0), 2, got, exp, bad, sok);
      vectors++;
      if (got !== exp || bad !== 0 || sok !== 1'b1) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h bad=%0d start_ok=%b", it, got, exp, bad, sok);
      end
    end
  endtask

  task automatic test_timeout();
    logic [127:0] got, exp;
    int bad, k;
    logic sok, seen_valid;
    i_fDec = 1'b0;
    load_block(rnd128(), 0, '0);
    k = 0; seen_valid = 1'b0;
    while (k < TO + 10 && o_fTimeout !== 1'b1) begin
      tick(); k++;
      if (o_fByteValid === 1'b1) seen_valid = 1'b1;
    end
    vectors++;
    if (k !== TO + 1 || seen_valid !== 1'b0) begin
      miscompares++; $display("FAIL timeout_time: rose after %0d cycles want %0d", k, TO + 1);
    end
    vectors++;
    if (o_fBusy !== 1'b0 || o_fByteReady !== 1'b1) begin
      miscompares++; $display("FAIL timeout_load: busy=%b ready=%b want 0/1", o_fBusy, o_fByteReady);
    end
    // A stray done while in LOAD must be ignored.
    i_fCoreDone = 1'b1; i_CoreData = rnd128();
    tick();
    i_fCoreDone = 1'b0;
    tick();
    vectors++;
    if (o_fByteValid !== 1'b0 || o_fBusy !== 1'b0) begin
      miscompares++; $display("FAIL load_ignores_done: valid=%b busy=%b want 0/0", o_fByteValid, o_fBusy);
    end
    run_block(rnd128(), 0, '0, 1'b1, 4, 2, got, exp, bad, sok);
    vectors++;
    if (got !== exp || bad !== 0 || o_fTimeout !== 1'b1) begin
      miscompares++;
      $display("FAIL after_timeout: got %h want %h bad=%0d to=%b", got, exp, bad, o_fTimeout);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, exp, data;
    int bad;
    logic sok;
    i_fDec = 1'b0;
    load_block(rnd128(), 0, '0);
    repeat (3) tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    reset_model();
    vectors++;
    if (o_fByteReady !== 1'b1 || o_fBusy !== 1'b0 || o_fByteValid !== 1'b0 || o_Byte !== 8'h00 ||
        o_fCoreStart !== 1'b0 || o_fCoreDec !== 1'b0 || o_fTimeout !== 1'b0 ||
        o_CoreText !== '0 || o_CoreKey !== '0) begin
      miscompares++;
      $display("FAIL rst_in_wait: ready=%b busy=%b valid=%b to=%b text=%h key=%h",
               o_fByteReady, o_fBusy, o_fByteValid, o_fTimeout, o_CoreText, o_CoreKey);
    end
    i_fCoreDone = 1'b1; i_CoreData = rnd128();
    tick();
    i_fCoreDone = 1'b0;
    tick();
    vectors++;
    if (o_fByteValid !== 1'b0 || o_fBusy !== 1'b0) begin
      miscompares++; $display("FAIL late_done: valid=%b busy=%b want 0/0", o_fByteValid, o_fBusy);
    end
    // Reset partway through the output stream.
    i_fDec = 1'b0;
    load_block(rnd128(), 16, rnd128());
    data = core_fn(m_key, m_text, 1'b0);
    wait_phase(2, data, m_text, m_key, 1'b0, bad);
    i_fByteReady = 1'b1;
    repeat (5) tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0; i_fByteReady = 1'b0;
    reset_model();
    vectors++;
    if (o_fByteReady !== 1'b1 || o_fBusy !== 1'b0 || o_fByteValid !== 1'b0 ||
        o_Byte !== 8'h00 || o_CoreKey !== '0 || bad !== 0) begin
      miscompares++;
      $display("FAIL rst_in_send: ready=%b busy=%b valid=%b byte=%h bad=%0d",
               o_fByteReady, o_fBusy, o_fByteValid, o_Byte, bad);
    end
    run_block(rnd128(), 16, rnd128(), 1'b0, 1, 0, got, exp, bad, sok);
    vectors++;
    if (got !== exp || bad !== 0 || sok !== 1'b1) begin
      miscompares++; $display("FAIL after_reset: got %h want %h bad=%0d", got, exp, bad);
    end
  endtask

`ifdef AES_SEQ_CBC_EN
  task automatic test_cbc();
    logic [127:0] p, k, g1, g2, d1, d2, exp;
    int bad;
    logic sok;
    p = rnd128(); k = rnd128();
    chain_clear();
    run_block(p, 16, k, 1'b0, 2, 0, g1, exp, bad, sok);
    vectors++;
    if (g1 !== exp || bad !== 0) begin miscompares++; $display("FAIL cbc_enc1: got %h want %h", g1, exp); end
    run_block(p, 0, '0, 1'b0, 2, 0, g2, exp, bad, sok);
    vectors++;
    if (g2 !== exp || bad !== 0) begin miscompares++; $display("FAIL cbc_enc2: got %h want %h", g2, exp); end
    vectors++;
    if (g1 === g2) begin miscompares++; $display("FAIL cbc_differ: got %h twice want distinct", g1); end
    chain_clear();
    run_block(g1, 0, '0, 1'b1, 2, 0, d1, exp, bad, sok);
    run_block(g2, 0, '0, 1'b1, 2, 0, d2, exp, bad, sok);
    vectors++;
    if (d1 !== p || d2 !== p) begin
      miscompares++; $display("FAIL cbc_dec: got %h %h want %h", d1, d2, p);
    end
  endtask
`endif

  initial begin
    i_Rst = 1'b1; i_Byte = '0; i_fByteValid = 1'b0; i_fKeySel = 1'b0; i_fDec = 1'b0;
    i_fByteReady = 1'b0; i_CoreData = '0; i_fCoreDone = 1'b0;
`ifdef AES_SEQ_CBC_EN
    i_fChainClr = 1'b0;
`endif
    reset_model();
    test_reset();
    test_fips();
    test_fips_dec();
    test_done_at_limit();
    test_backpressure();
    test_key_wrap();
    test_random();
    test_timeout();
    test_reset_mid();
`ifdef AES_SEQ_CBC_EN
    test_cbc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
